// File: rtl/mult_pp_accum_stage.sv
// mult_pp_accum_stage: compresses partial-product pairs and shift-accumulates up to four beats into a MUL/MULH/MULW result
module mult_pp_accum_stage #(
   parameter int PP_WIDTH  = 69,
   parameter int ACC_WIDTH = 128,
   parameter int OUT_WIDTH = 64
) (
   input  logic                 cpuclk,
   input  logic                 cpurst,
   input  logic                 flush,
   input  logic                 pp_vld,
   output logic                 pp_rdy,
   input  logic [PP_WIDTH-1:0]  pp_sum0,
   input  logic [PP_WIDTH-1:0]  pp_sum1,
   input  logic [1:0]           pp_shift,
   input  logic                 pp_last,
   input  logic [1:0]           pp_op,
   output logic                 res_vld,
   input  logic                 res_rdy,
   output logic [OUT_WIDTH-1:0] res_data
);
   typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;
   state_t               state;
   logic [PP_WIDTH-1:0]  s1_pp;
   logic [1:0]           s1_shift;
   logic                 s1_first;
   logic                 s1_last;
   logic                 s1_vld;
   logic [1:0]           op;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] addend;
   logic                 accept;
   assign pp_rdy = (state == IDLE) || (state == ACC);
   assign res_vld = state == DONE;
   assign accept = pp_vld && pp_rdy;
   assign addend = {{(ACC_WIDTH-PP_WIDTH){s1_pp[PP_WIDTH-1]}}, s1_pp} << {s1_shift, 5'd0};
   assign res_data = op == 2'b01 ? acc[ACC_WIDTH-1 -: OUT_WIDTH]
                   : op == 2'b10 ? {{(OUT_WIDTH-32){acc[31]}}, acc[31:0]}
                   : acc[OUT_WIDTH-1:0];
   // flush leaves acc alone: the next first beat overwrites it anyway
   always_ff @(posedge cpuclk) begin
      if (cpurst) begin
         state    <= IDLE;
         s1_vld   <= 1'b0;
         s1_pp    <= '0;
         s1_shift <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         op       <= '0;
         acc      <= '0;
      end else if (flush) begin
         state  <= IDLE;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_pp    <= pp_sum0 + pp_sum1;
            s1_shift <= pp_shift;
            s1_first <= state == IDLE;
            s1_last  <= pp_last;
         end
         if (accept && state == IDLE) op <= pp_op;
         if (s1_vld) acc <= (s1_first ? '0 : acc) + addend;
         state <= state == WAIT ? ((s1_vld && s1_last) ? DONE : IDLE)
                : state == DONE ? (res_rdy ? IDLE : DONE)
                : accept ? (pp_last ? WAIT : ACC)
                : state;
      end
   end
endmodule

// File: tb/tb_mult_pp_accum_stage.sv
// tb_mult_pp_accum_stage: directed vector table plus multi-beat, back-pressure, flush and reset sequences
module tb_mult_pp_accum_stage;
   logic        cpuclk = 1'b0;
   logic        cpurst = 1'b1;
   logic        flush = 1'b0;
   logic        pp_vld = 1'b0;
   logic        pp_rdy;
   logic [68:0] pp_sum0 = '0;
   logic [68:0] pp_sum1 = '0;
   logic [1:0]  pp_shift = '0;
   logic        pp_last = 1'b0;
   logic [1:0]  pp_op = '0;
   logic        res_vld;
   logic        res_rdy = 1'b0;
   logic [63:0] res_data;
   int total = 0;
   int bad = 0;
   localparam logic [68:0] SQ = 69'h0_FFFF_FFFE_0000_0001;
   typedef struct {
      logic [68:0] s0;
      logic [68:0] s1;
      logic [1:0]  op;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[8];

   mult_pp_accum_stage dut (
      .cpuclk(cpuclk), .cpurst(cpurst), .flush(flush),
      .pp_vld(pp_vld), .pp_rdy(pp_rdy), .pp_sum0(pp_sum0), .pp_sum1(pp_sum1),
      .pp_shift(pp_shift), .pp_last(pp_last), .pp_op(pp_op),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data)
   );

   always #5 cpuclk = ~cpuclk;

   task automatic tick;
      @(posedge cpuclk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [68:0] s0, input logic [68:0] s1, input logic [1:0] sh,
                       input logic last, input logic [1:0] op);
      pp_vld = 1'b1; pp_sum0 = s0; pp_sum1 = s1; pp_shift = sh; pp_last = last; pp_op = op;
      check("beat_rdy", {63'd0, pp_rdy}, 64'd1);
      tick;
      pp_vld = 1'b0; pp_op = 2'b11;
   endtask

   task automatic take_result(input string name, input logic [63:0] exp);
      check({name, "_vld"}, {63'd0, res_vld}, 64'd1);
      check({name, "_data"}, res_data, exp);
      res_rdy = 1'b1;
      tick;
      res_rdy = 1'b0;
      check({name, "_vld_drop"}, {63'd0, res_vld}, 64'd0);
      check({name, "_rdy_back"}, {63'd0, pp_rdy}, 64'd1);
   endtask

   task automatic single(input string name, input logic [68:0] s0, input logic [68:0] s1,
                         input logic [1:0] op, input logic [63:0] exp);
      beat(s0, s1, 2'd0, 1'b1, op);
      check({name, "_t1_vld"}, {63'd0, res_vld}, 64'd0);
      check({name, "_t1_rdy"}, {63'd0, pp_rdy}, 64'd0);
      tick;
      take_result(name, exp);
   endtask

   task automatic square_beats(input logic [1:0] op, input int n);
      logic [1:0] sh [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
      for (int i = 0; i < n; i++) beat(SQ, '0, sh[i], i == 3, op);
   endtask

   initial begin
      vecs[0] = '{69'h0_8000_0000, 69'd0, 2'b10, 64'hFFFF_FFFF_8000_0000};
      vecs[1] = '{69'h0_FFFF_FFFF, 69'd1, 2'b00, 64'h0000_0001_0000_0000};
      vecs[2] = '{69'h1F_FFFF_FFFF_FFFF_FFFF, 69'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{69'd7, 69'd0, 2'b10, 64'd7};
      vecs[4] = '{69'd5, 69'h1F_FFFF_FFFF_FFFF_FFFE, 2'b11, 64'd3};
      vecs[5] = '{69'd0, 69'h1F_FFFF_FFFF_FFFF_FFFB, 2'b00, 64'hFFFF_FFFF_FFFF_FFFB};
      vecs[6] = '{69'h1_2345_6789_7FFF_FFFF, 69'd0, 2'b10, 64'h0000_0000_7FFF_FFFF};
      vecs[7] = '{69'h10_0000_0000_0000_0000, 69'h10_0000_0000_0000_0000, 2'b01, 64'd0};
      tick;
      tick;
      check("rst_rdy", {63'd0, pp_rdy}, 64'd1);
      check("rst_vld", {63'd0, res_vld}, 64'd0);
      check("rst_data", res_data, 64'd0);
      cpurst = 1'b0;
      tick;
      for (int i = 0; i < 8; i++) single($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].op, vecs[i].exp);
      // four beats from T: nothing valid in T+4, result in T+5
      square_beats(2'b01, 4);
      check("sq_h_t4", {63'd0, res_vld}, 64'd0);
      tick;
      take_result("sq_mulh", 64'hFFFF_FFFF_FFFF_FFFE);
      square_beats(2'b00, 4);
      tick;
      for (int i = 0; i < 5; i++) begin
         check("bp_vld", {63'd0, res_vld}, 64'd1);
         check("bp_data", res_data, 64'd1);
         check("bp_rdy", {63'd0, pp_rdy}, 64'd0);
         tick;
      end
      take_result("sq_mul", 64'd1);
      square_beats(2'b01, 2);
      pp_vld = 1'b1; pp_sum0 = SQ; pp_shift = 2'd1; flush = 1'b1;
      tick;
      pp_vld = 1'b0; flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("fl_rdy", {63'd0, pp_rdy}, 64'd1);
         check("fl_vld", {63'd0, res_vld}, 64'd0);
         tick;
      end
      single("fl_mulw", 69'd7, 69'd0, 2'b10, 64'd7);
      square_beats(2'b01, 2);
      pp_vld = 1'b1; pp_sum0 = SQ; pp_shift = 2'd1; cpurst = 1'b1;
      tick;
      pp_vld = 1'b0; cpurst = 1'b0;
      check("rs_data", res_data, 64'd0);
      for (int i = 0; i < 4; i++) begin
         check("rs_rdy", {63'd0, pp_rdy}, 64'd1);
         check("rs_vld", {63'd0, res_vld}, 64'd0);
         tick;
      end
      single("rs_mulw", 69'd7, 69'd0, 2'b10, 64'd7);
      single("pre_fd", 69'd9, 69'd0, 2'b00, 64'd9);
      beat(69'd4, 69'd0, 2'd0, 1'b1, 2'b00);
      tick;
      flush = 1'b1; res_rdy = 1'b1;
      tick;
      flush = 1'b0; res_rdy = 1'b0;
      check("fd_vld", {63'd0, res_vld}, 64'd0);
      check("fd_rdy", {63'd0, pp_rdy}, 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
